// File: rtl/systolic_result_writer.sv
// rtl/systolic_result_writer.sv - buffers systolic result rows and serialises them onto a memory write port
module systolic_result_writer #(
    parameter int M          = 5,
    parameter int K          = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [DATA_WIDTH*K-1:0] y_in,
    input  logic                    y_valid,
    output logic                    mem_wr_en,
    output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    input  logic                    mem_wr_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ROW_W = $clog2(M + 1);
    localparam int COL_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ROW_W-1:0]        rows_in_q, rows_in_d;
    logic [ROW_W-1:0]        rows_out_q, rows_out_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;

    logic [DATA_WIDTH*K-1:0] fifo_mem [FIFO_DEPTH];

    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    offer;
    logic                    beat;
    logic                    last_col;
    logic                    pop;
    logic                    capture;
    logic                    push;
    logic                    drop;
    logic [DATA_WIDTH*K-1:0] head_row;
    logic [DATA_WIDTH-1:0]   head_word;
    logic [ADDR_WIDTH-1:0]   beat_addr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign offer      = (state_q == S_RUN) && !fifo_empty;
    assign beat       = offer && mem_wr_ready;
    assign last_col   = (col_q == COL_W'(K - 1));
    assign pop        = beat && last_col;

    // A full FIFO still accepts a row when the head leaves in the same cycle.
    assign capture    = (state_q == S_RUN) && y_valid && (rows_in_q < ROW_W'(M));
    assign push       = capture && (!fifo_full || pop);
    assign drop       = capture && fifo_full && !pop;

    assign head_row   = fifo_mem[rd_ptr_q];

    always_comb begin
        head_word = '0;
        for (int j = 0; j < K; j++) begin
            if (col_q == COL_W'(j)) begin
                head_word = head_row[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Row-major address, deliberately truncated so it wraps at 2^ADDR_WIDTH.
    assign beat_addr = base_q + ADDR_WIDTH'(rows_out_q) * ADDR_WIDTH'(K) + ADDR_WIDTH'(col_q);

    assign mem_wr_en   = offer;
    assign mem_wr_addr = offer ? beat_addr : '0;
    assign mem_wr_data = offer ? head_word : '0;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign overflow    = ovf_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if ((rows_in_q == ROW_W'(M)) && fifo_empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        base_d     = base_q;
        rows_in_d  = rows_in_q;
        rows_out_d = rows_out_q;
        col_d      = col_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        if ((state_q == S_IDLE) && start) begin
            base_d     = base_addr;
            rows_in_d  = '0;
            rows_out_d = '0;
            col_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
        end else if (state_q == S_RUN) begin
            if (beat) begin
                if (last_col) begin
                    col_d      = '0;
                    rd_ptr_d   = ptr_inc(rd_ptr_q);
                    rows_out_d = rows_out_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            if (capture) begin
                rows_in_d = rows_in_q + ROW_W'(1);
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            rows_in_q  <= '0;
            rows_out_q <= '0;
            col_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            base_q     <= base_d;
            rows_in_q  <= rows_in_d;
            rows_out_q <= rows_out_d;
            col_q      <= col_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= y_in;
        end
    end

endmodule
